// File: rtl/bt656_tx.sv
// RGB pixel stream to 10-bit BT.656 YCbCr 4:2:2 words with EAV/SAV timing and blanking.
// Optional BT656TX_CHROMA_AVG_EN: chroma is the rounded mean of both pixels of a pair.
module bt656_tx #(
  parameter int unsigned HACT   = 720,
  parameter int unsigned HBLANK = 138,
  parameter int unsigned VBLANK = 45,
  parameter int unsigned VTOTAL = 525
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        outde,
  input  logic [24:0] outdat,
  output logic        outrdy,
  output logic [9:0]  dadat,
  output logic        dahs,
  output logic        davs,
  output logic        underrun,
  output logic        syncerr
);

  localparam int unsigned LineWords = 2 * (HACT + HBLANK);
  localparam int unsigned WW = $clog2(LineWords);
  localparam int unsigned LN = $clog2(VTOTAL);
  localparam logic [WW-1:0] WEavEnd = WW'(4);
  localparam logic [WW-1:0] WSav = WW'(2 * HBLANK - 4);
  localparam logic [WW-1:0] WAct = WW'(2 * HBLANK);
  localparam logic [WW-1:0] WSchedEnd = WW'(LineWords - 5);
  localparam logic [WW-1:0] WLast = WW'(LineWords - 1);
  localparam logic [LN-1:0] LVbl = LN'(VBLANK);
  localparam logic [LN-1:0] LLast = LN'(VTOTAL - 1);
  localparam logic [9:0] YBlack = 10'h040;
  localparam logic [9:0] CBlack = 10'h200;

  function automatic logic [9:0] conv(input logic [23:0] p, input int kr, input int kg,
                                      input int kb, input int off);
    int s;
    s = kr * int'(p[23:16]) + kg * int'(p[15:8]) + kb * int'(p[7:0]) + 8192;
    s = (s >>> 14) + off;
    if (s < 4) s = 4;
    else if (s > 1019) s = 1019;
    return s[9:0];
  endfunction

  function automatic logic [9:0] xy(input logic v, input logic h);
    return {1'b1, 1'b0, v, h, v ^ h, h, v, v ^ h, 2'b00};
  endfunction

  logic [WW-1:0] word_q, word_d;
  logic [LN-1:0] line_q, line_d;
  logic [24:0]   mem_q [4];
  logic [1:0]    rd_q, wr_q;
  logic [2:0]    cnt_q;
  logic [23:0]   a_q, b_q;
  logic          a_ok_q, b_ok_q;
  logic [9:0]    y0_q, y1_q, cb_q, cr_q, y0_d, y1_d, cb_d, cr_d;
  logic          blk_q, blk_d, underrun_q, syncerr_q;
  logic [9:0]    dadat_q, dadat_d;
  logic          dahs_q, davs_q;

  logic [24:0] head;
  logic        empty, full, push, pop, set_ur, set_se;
  logic        vbl, sched, due, due_even, due_odd, latch, first_px, frame_end;
  logic [1:0]  rel;

  assign head      = mem_q[rd_q];
  assign empty     = (cnt_q == 3'd0);
  assign full      = (cnt_q == 3'd4);
  assign outrdy    = !full && !reset;
  assign push      = outde && outrdy;
  assign vbl       = (line_q < LVbl);
  assign rel       = 2'(word_q - WSav);
  // Pixel pair k is popped 4 and 3 words before its Cb slot and converted 1 word before it.
  assign sched     = !vbl && (word_q >= WSav) && (word_q <= WSchedEnd);
  assign due       = sched && !rel[1];
  assign due_even  = due && !rel[0];
  assign due_odd   = due && rel[0];
  assign latch     = sched && (rel == 2'd3);
  assign first_px  = (line_q == LVbl) && (word_q == WSav);
  assign frame_end = (word_q == WLast) && (line_q == LLast);

  always_comb begin
    pop    = 1'b0;
    set_ur = 1'b0;
    set_se = 1'b0;
    if (vbl) begin
      // Drop stray pixels until a frame-start pixel sits at the head.
      pop = !empty && !head[24];
    end else if (due && !blk_q) begin
      if (empty) set_ur = 1'b1;
      else if (head[24] && !first_px) set_se = 1'b1;
      else pop = 1'b1;
    end
  end

  logic [9:0] ya, cba, cra, yb;
  assign ya  = conv(a_q, 16843, 33030, 6423, 64);
  assign cba = conv(a_q, -9699, -19071, 28770, 512);
  assign cra = conv(a_q, 28770, -24117, -4653, 512);
  assign yb  = conv(b_q, 16843, 33030, 6423, 64);

`ifdef BT656TX_CHROMA_AVG_EN
  logic [9:0]  cbb, crb;
  logic [10:0] cb_sum, cr_sum;
  assign cbb    = conv(b_q, -9699, -19071, 28770, 512);
  assign crb    = conv(b_q, 28770, -24117, -4653, 512);
  assign cb_sum = {1'b0, cba} + {1'b0, cbb} + 11'd1;
  assign cr_sum = {1'b0, cra} + {1'b0, crb} + 11'd1;
`endif

  always_comb begin
    y0_d = y0_q;
    y1_d = y1_q;
    cb_d = cb_q;
    cr_d = cr_q;
    if (latch) begin
`ifdef BT656TX_CHROMA_AVG_EN
      if (a_ok_q && b_ok_q) begin
        y0_d = ya;
        y1_d = yb;
        cb_d = cb_sum[10:1];
        cr_d = cr_sum[10:1];
      end else begin
        y0_d = YBlack;
        y1_d = YBlack;
        cb_d = CBlack;
        cr_d = CBlack;
      end
`else
      y0_d = a_ok_q ? ya : YBlack;
      cb_d = a_ok_q ? cba : CBlack;
      cr_d = a_ok_q ? cra : CBlack;
      y1_d = b_ok_q ? yb : YBlack;
`endif
    end
  end

  always_comb begin
    dadat_d = CBlack;
    if (word_q < WEavEnd) begin
      case (word_q[1:0])
        2'd0:    dadat_d = 10'h3FF;
        2'd1:    dadat_d = 10'h000;
        2'd2:    dadat_d = 10'h000;
        default: dadat_d = xy(vbl, 1'b1);
      endcase
    end else if ((word_q >= WSav) && (word_q < WAct)) begin
      case (rel)
        2'd0:    dadat_d = 10'h3FF;
        2'd1:    dadat_d = 10'h000;
        2'd2:    dadat_d = 10'h000;
        default: dadat_d = xy(vbl, 1'b0);
      endcase
    end else if ((word_q < WAct) || vbl) begin
      dadat_d = word_q[0] ? YBlack : CBlack;
    end else begin
      case (rel)
        2'd0:    dadat_d = cb_q;
        2'd1:    dadat_d = y0_q;
        2'd2:    dadat_d = cr_q;
        default: dadat_d = y1_q;
      endcase
    end
  end

  always_comb begin
    word_d = (word_q == WLast) ? '0 : word_q + 1'b1;
    line_d = line_q;
    if (word_q == WLast) line_d = (line_q == LLast) ? '0 : line_q + 1'b1;
    blk_d = frame_end ? 1'b0 : (blk_q || set_se);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= outdat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q     <= '0;
      line_q     <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      a_ok_q     <= 1'b0;
      b_ok_q     <= 1'b0;
      y0_q       <= YBlack;
      y1_q       <= YBlack;
      cb_q       <= CBlack;
      cr_q       <= CBlack;
      blk_q      <= 1'b0;
      underrun_q <= 1'b0;
      syncerr_q  <= 1'b0;
      dadat_q    <= YBlack;
      dahs_q     <= 1'b1;
      davs_q     <= 1'b1;
    end else begin
      word_q     <= word_d;
      line_q     <= line_d;
      rd_q       <= rd_q + {1'b0, pop};
      wr_q       <= wr_q + {1'b0, push};
      cnt_q      <= cnt_q + {2'b00, push} - {2'b00, pop};
      if (due_even) begin
        a_q    <= head[23:0];
        a_ok_q <= pop;
      end
      if (due_odd) begin
        b_q    <= head[23:0];
        b_ok_q <= pop;
      end
      y0_q       <= y0_d;
      y1_q       <= y1_d;
      cb_q       <= cb_d;
      cr_q       <= cr_d;
      blk_q      <= blk_d;
      underrun_q <= underrun_q || set_ur;
      syncerr_q  <= syncerr_q || set_se;
      dadat_q    <= dadat_d;
      dahs_q     <= (word_q < WAct);
      davs_q     <= vbl;
    end
  end

  assign dadat    = dadat_q;
  assign dahs     = dahs_q;
  assign davs     = davs_q;
  assign underrun = underrun_q;
  assign syncerr  = syncerr_q;

endmodule
